// File: rtl/oam_dma.sv
// OAM DMA initiator: copies LENGTH bytes from {src_hi,8'h00} to DST_BASE, one byte per clock.
// Optional start delay enabled by defining OAM_DMA_START_DELAY_EN.
module oam_dma #(
  parameter int unsigned LENGTH      = 160,
  parameter logic [15:0] DST_BASE    = 16'hFE00,
  parameter logic [15:0] REG_ADDR    = 16'hFF46,
  parameter int unsigned START_DELAY = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_reg_wr_en,
  input  logic [15:0] i_reg_addr,
  input  logic [7:0]  i_reg_wr_data,
  output logic [7:0]  o_reg_rd_data,
  output logic        o_busy,
  output logic [15:0] o_mem_rd_addr,
  input  logic [7:0]  i_mem_rd_data,
  output logic        o_mem_wr_en,
  output logic [15:0] o_mem_wr_addr,
  output logic [7:0]  o_mem_wr_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_XFER  = 2'd2
  } state_t;

  localparam logic [8:0] LAST_IDX = 9'(LENGTH - 1);

  state_t      state_q;
  logic [7:0]  reg_q;
  logic [7:0]  src_hi_q;
  logic [8:0]  rd_idx_q;
  logic        rd_valid_q;
  logic        busy_q;
  logic [15:0] rd_addr_q;
  logic        wr_en_q;
  logic [15:0] wr_addr_q;
`ifdef OAM_DMA_START_DELAY_EN
  localparam logic [15:0] DLY_LAST = 16'(START_DELAY - 1);
  logic [15:0] dly_cnt_q;
`endif

  logic       trigger_s;
  logic [7:0] src_hi_d;

  assign trigger_s = i_reg_wr_en && (i_reg_addr == REG_ADDR);

  // Echo RAM (E000-FDFF) mirrors C000-DDFF, so high source pages fold down by 0x20.
  always_comb begin
    src_hi_d = i_reg_wr_data;
    if (i_reg_wr_data >= 8'hE0) begin
      src_hi_d = i_reg_wr_data - 8'h20;
    end else begin
      src_hi_d = i_reg_wr_data;
    end
  end

  // Transfer FSM; rd_valid_q marks a read issued this cycle whose write lands next cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      reg_q      <= 8'h00;
      src_hi_q   <= 8'h00;
      rd_idx_q   <= 9'd0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      rd_addr_q  <= 16'h0000;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 16'h0000;
`ifdef OAM_DMA_START_DELAY_EN
      dly_cnt_q  <= 16'd0;
`endif
    end else if (trigger_s) begin
      // A retrigger drops the in-flight read; the write already on the bus this cycle completes.
      reg_q    <= i_reg_wr_data;
      src_hi_q <= src_hi_d;
      busy_q   <= 1'b1;
      wr_en_q  <= 1'b0;
      rd_idx_q <= 9'd0;
`ifdef OAM_DMA_START_DELAY_EN
      dly_cnt_q <= 16'd0;
      if (START_DELAY == 0) begin
        state_q    <= ST_XFER;
        rd_valid_q <= 1'b1;
        rd_addr_q  <= {src_hi_d, 8'h00};
      end else begin
        state_q    <= ST_DELAY;
        rd_valid_q <= 1'b0;
      end
`else
      state_q    <= ST_XFER;
      rd_valid_q <= 1'b1;
      rd_addr_q  <= {src_hi_d, 8'h00};
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          busy_q     <= 1'b0;
          wr_en_q    <= 1'b0;
          rd_valid_q <= 1'b0;
        end
        ST_DELAY: begin
`ifdef OAM_DMA_START_DELAY_EN
          if (dly_cnt_q == DLY_LAST) begin
            state_q    <= ST_XFER;
            rd_valid_q <= 1'b1;
            rd_idx_q   <= 9'd0;
            rd_addr_q  <= {src_hi_q, 8'h00};
          end else begin
            dly_cnt_q <= dly_cnt_q + 16'd1;
          end
`else
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          wr_en_q <= 1'b0;
`endif
        end
        ST_XFER: begin
          wr_en_q   <= rd_valid_q;
          wr_addr_q <= DST_BASE + {7'd0, rd_idx_q};
          if (rd_valid_q && (rd_idx_q < LAST_IDX)) begin
            rd_idx_q  <= rd_idx_q + 9'd1;
            // Low byte only: the source address never carries into the page byte.
            rd_addr_q <= {src_hi_q, rd_idx_q[7:0] + 8'd1};
          end else if (rd_valid_q) begin
            rd_valid_q <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          busy_q     <= 1'b0;
          wr_en_q    <= 1'b0;
          rd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_reg_rd_data = reg_q;
  assign o_busy        = busy_q;
  assign o_mem_rd_addr = rd_addr_q;
  assign o_mem_wr_en   = wr_en_q;
  assign o_mem_wr_addr = wr_addr_q;
  assign o_mem_wr_data = i_mem_rd_data;

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: a memory model feeds reads and expected OAM writes are queued.
module tb_oam_dma;
  localparam int LEN = 160;
`ifdef OAM_DMA_START_DELAY_EN
  localparam int DLY = 4;
`else
  localparam int DLY = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reg_wr_en = 1'b0;
  logic [15:0] reg_addr = 16'h0000;
  logic [7:0]  reg_wr_data = 8'h00;
  logic [7:0]  reg_rd_data;
  logic        busy;
  logic [15:0] rd_addr;
  logic [7:0]  mem_rd_data = 8'h00;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  logic [7:0]  mem [0:65535];

  oam_dma dut (
    .i_clk(clk), .i_rst(rst),
    .i_reg_wr_en(reg_wr_en), .i_reg_addr(reg_addr), .i_reg_wr_data(reg_wr_data),
    .o_reg_rd_data(reg_rd_data), .o_busy(busy),
    .o_mem_rd_addr(rd_addr), .i_mem_rd_data(mem_rd_data),
    .o_mem_wr_en(wr_en), .o_mem_wr_addr(wr_addr), .o_mem_wr_data(wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] fold(input logic [7:0] d);
    logic [7:0] r;
    r = (d >= 8'hE0) ? d - 8'h20 : d;
    return r;
  endfunction

  always @(posedge clk) begin
    mem_rd_data <= mem[rd_addr];
    if (wr_en === 1'b1) mem[wr_addr] <= wr_data;
  end

  always @(negedge clk) begin
    logic [23:0] e;
    if (wr_en === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write got addr=%h data=%h required no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL sb_write got addr=%h data=%h required addr=%h data=%h",
                   wr_addr, wr_data, e[23:8], e[7:0]);
        end
      end
    end
  end

  task automatic push_xfer(input logic [7:0] d);
    logic [7:0] hi;
    logic [15:0] src;
    hi = fold(d);
    for (int i = 0; i < LEN; i++) begin
      src = {hi, 8'h00} + 16'(i);
      exp_q.push_back({16'hFE00 + 16'(i), pat(src)});
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    reg_wr_en = 1'b1; reg_addr = a; reg_wr_data = d;
    @(negedge clk);
    reg_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({reg_rd_data, busy, rd_addr, wr_en, wr_addr} !== 42'd0) begin
      errors++;
      $display("FAIL reset got reg=%h busy=%b rd=%h we=%b wa=%h required all zero",
               reg_rd_data, busy, rd_addr, wr_en, wr_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_full(input logic [7:0] d);
    int n;
    int bad;
    logic [15:0] src;
    src = {fold(d), 8'h00};
    push_xfer(d);
    do_write(16'hFF46, d);
    n = 0;
    repeat (DLY) begin
      if (busy === 1'b1) n++;
      @(negedge clk);
    end
    checks++;
    if (rd_addr !== src || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_read got rd=%h busy=%b required rd=%h busy=1", rd_addr, busy, src);
    end
    while (busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== LEN + 1 + DLY) begin
      errors++;
      $display("FAIL busy_len got %0d required %0d", n, LEN + 1 + DLY);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL writes_missing got %0d left required 0", exp_q.size());
      exp_q.delete();
    end
    checks++;
    if (reg_rd_data !== d) begin
      errors++;
      $display("FAIL readback got %h required %h", reg_rd_data, d);
    end
    bad = 0;
    for (int i = 0; i < LEN; i++)
      if (mem[16'hFE00 + 16'(i)] !== pat(src + 16'(i))) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL oam_image got %0d bad bytes required 0 (src %h)", bad, src);
    end
  endtask

  task automatic test_ignored();
    do_write(16'hFF45, 8'h12);
    do_write(16'hFF47, 8'h34);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL ignored_busy got %b required 0", busy);
      end
      @(negedge clk);
    end
    checks++;
    if (reg_rd_data !== 8'hF0) begin
      errors++;
      $display("FAIL ignored_readback got %h required f0", reg_rd_data);
    end
  endtask

  task automatic test_retrigger();
    int n;
    int bad;
    push_xfer(8'hC0);
    do_write(16'hFF46, 8'hC0);
    n = 0;
    for (int c = 1; c <= 50 + DLY; c++) begin
      if (busy === 1'b1) n++;
      @(negedge clk);
    end
    checks++;
    if (rd_addr !== 16'hC032) begin
      errors++;
      $display("FAIL retrig_point got %h required c032", rd_addr);
    end
    if (busy === 1'b1) n++;
    reg_wr_en = 1'b1; reg_addr = 16'hFF46; reg_wr_data = 8'hC8;
    @(negedge clk);
    reg_wr_en = 1'b0;
    checks++;
    if (exp_q.size() != LEN - 50) begin
      errors++;
      $display("FAIL retrig_old_writes got %0d left required %0d", exp_q.size(), LEN - 50);
    end
    exp_q.delete();
    push_xfer(8'hC8);
    while (busy === 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== 51 + DLY + LEN + 1 + DLY) begin
      errors++;
      $display("FAIL retrig_busy got %0d required %0d", n, 51 + DLY + LEN + 1 + DLY);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL retrig_missing got %0d left required 0", exp_q.size());
      exp_q.delete();
    end
    bad = 0;
    for (int i = 0; i < LEN; i++)
      if (mem[16'hFE00 + 16'(i)] !== pat(16'hC800 + 16'(i))) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL retrig_image got %0d bad bytes required 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] snap [0:79];
    int bad;
    for (int i = 0; i < 80; i++) snap[i] = mem[16'hFE50 + 16'(i)];
    push_xfer(8'hD5);
    do_write(16'hFF46, 8'hD5);
    repeat (80 + DLY) @(negedge clk);
    checks++;
    if (rd_addr !== 16'hD550) begin
      errors++;
      $display("FAIL rst_point got %h required d550", rd_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || wr_en !== 1'b0 || reg_rd_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_abort got busy=%b we=%b reg=%h required 0 0 00", busy, wr_en, reg_rd_data);
    end
    rst = 1'b0;
    checks++;
    if (exp_q.size() != LEN - 80) begin
      errors++;
      $display("FAIL rst_writes got %0d left required %0d", exp_q.size(), LEN - 80);
    end
    exp_q.delete();
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle got busy=%b required 0", busy);
    end
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      if (mem[16'hFE50 + 16'(i)] !== snap[i]) bad++;
      if (mem[16'hFE00 + 16'(i)] !== pat(16'hD500 + 16'(i))) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rst_image got %0d bad bytes required 0", bad);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = pat(16'(a));
    test_reset();
    test_full(8'hC1);
    test_full(8'hF0);
    test_ignored();
    test_retrigger();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
